jtag_host_drv: RTL
==================

# jtag_host_drv

Synthesizable JTAG host (TAP controller driver) that generates TCK/TMS/TDI and samples TDO to drive the SoC debug TAP from inside the simulation top. It replaces the external VPI-based JTAG driver. A local command interface requests TAP reset, IR scans, DR scans and Run-Test/Idle padding, and each command returns the captured TDO bits. It sits in the test harness, wired to the SoC `io_pads_jtag_*` pads.

## Interface
Parameters:
- `CLK_DIV`, default 2: TCK half-period in `clk` cycles; legal values 1..255.

Ports:
- `clk`  in  1  — single clock; everything is synchronous to its rising edge.
- `rst_n`  in  1  — reset, synchronous, active-low.
- `cmd_valid`  in  1  — command request.
- `cmd_ready`  out  1  — command accepted when high with `cmd_valid`.
- `cmd_op`  in  2  — 00 TAP reset, 01 IR scan, 10 DR scan, 11 idle.
- `cmd_len`  in  7  — shift length for scans, or TCK count for idle. 0 is treated as 1; values above 64 are clamped to 64.
- `cmd_data`  in  64  — TDI bits; bit 0 is shifted first.
- `rsp_valid`  out  1  — response available.
- `rsp_ready`  in  1  — response consumed.
- `rsp_data`  out  64  — captured TDO. Bit i is TDO on shift i; bits ≥ len are 0.
- `busy`  out  1  — high from command accept until the response handshake.
- `jtag_tck`  out  1  — TCK; idles low.
- `jtag_tms`  out  1  — TMS.
- `jtag_tdi`  out  1  — TDI.
- `jtag_tdo`  in  1  — TDO from the target.

## Operation
- States: IDLE, HDR, SHIFT, POST, RSP.
  - IDLE → HDR on accept.
  - HDR → SHIFT (scans) or HDR → RSP (reset, idle).
  - SHIFT → POST after len bits.
  - POST → RSP.
  - RSP → IDLE on `rsp_ready`.
- `cmd_ready` = (state == IDLE). `busy` = !cmd_ready. `cmd_op`, `cmd_len` and `cmd_data` are latched on accept.
- Every command starts and ends in Run-Test/Idle, except op 00, which forces it.
- TMS sequences, one value per TCK:
  - Op 00: 1,1,1,1,1,0 (6 TCKs).
  - Op 11: len × 0.
  - Op 10 (DR scan):
    - Header 1,0,0.
    - Shift: TMS=0 for bits 0..len-2 and TMS=1 on bit len-1.
    - Post 1,0.
    - Total len+5 TCKs.
  - Op 01 (IR scan):
    - Header 1,1,0,0.
    - Shift: same as DR.
    - Post 1,0.
    - Total len+6 TCKs.
- TDI carries `cmd_data[i]` during shift i and 0 otherwise.
- TDO is sampled only during shift TCKs and is right-aligned into `rsp_data`. Ops 00 and 11 return `rsp_data` = 0.
- `rsp_valid` and `rsp_data` are held stable until `rsp_ready`. A new command is not accepted before that handshake.
- Reset values:
  - `jtag_tck` 0, `jtag_tms` 1, `jtag_tdi` 0.
  - `cmd_ready` 1, `busy` 0.
  - `rsp_valid` 0, `rsp_data` 0.
- Reset mid-command aborts immediately with no response. The TAP state is then undefined, and the user issues op 00 next.

## Timing
- One TCK = CLK_DIV cycles low + CLK_DIV cycles high. A half-period counter reloads to CLK_DIV-1.
- Let accept edge = E0. For TCK n (0-based):
  - TMS/TDI are updated at edge E0+2·CLK_DIV·n, with TCK low.
  - TCK rises at edge E0+2·CLK_DIV·n+CLK_DIV.
  - TDO is sampled from `jtag_tdo` at that same rising edge.
  - TCK falls at edge E0+2·CLK_DIV·(n+1).
- For a command of N TCKs, `rsp_valid` rises at edge E0+2·CLK_DIV·N. This is the same edge as the final TCK fall.
- TMS and TDI never change while TCK is high. TCK stays low in IDLE and RSP.
- With CLK_DIV=1, TCK toggles every cycle and the rules above still hold.
- Minimum command-to-command spacing is the response handshake + 1 cycle (the IDLE accept).

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles → outputs are `tck`=0, `tms`=1, `tdi`=0, `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0.
- Op 00, CLK_DIV=2 → TMS at TCK rising edges is 1,1,1,1,1,0. `rsp_valid` rises 24 cycles after accept with `rsp_data`=0. A bench TAP model ends in Run-Test/Idle.
- IR scan, len=5, data=0x01, CLK_DIV=2, TAP model IR capture value 0b00001:
  - TMS is 1,1,0,0,0,0,0,0,1,1,0 and TDI on the shift TCKs is 1,0,0,0,0.
  - `rsp_data`=0x01 and the model IR = 0x01.
  - `rsp_valid` rises 44 cycles after accept.
- DR scan, len=32, data=0, CLK_DIV=2, model IDCODE 0x1E200A6D → `rsp_data`=0x1E200A6D at 148 cycles. Then len=0 with op 11 runs exactly 1 TCK with TMS=0.
- Backpressure: hold `rsp_ready`=0 for 10 cycles after `rsp_valid` → `rsp_valid` and `rsp_data` stay stable and `cmd_ready` stays 0. A concurrent `cmd_valid` is ignored until the handshake, then accepted on the next cycle.
- Mid-scan reset: assert `rst_n`=0 during shift bit 10 of a DR len=32 → reset values appear on the next edge and no `rsp_valid` is produced. A following op 00 + DR scan returns the correct IDCODE.

Source files
------------

// File: rtl/jtag_host_drv.sv
`default_nettype none
// ============================================================================
// Module   : jtag_host_drv
// Purpose  : Synthesizable JTAG host. Turns local commands (TAP reset, IR
//            scan, DR scan, Run-Test/Idle padding) into TCK/TMS/TDI
//            sequences and returns the TDO bits captured during the shift.
// Ports    : clk, rst_n          - clock, synchronous active-low reset
//            cmd_valid/ready     - command handshake
//            cmd_op/len/data     - opcode, shift/idle length, TDI bits (LSB first)
//            rsp_valid/ready     - response handshake
//            rsp_data            - captured TDO, bit i = TDO of shift i
//            busy                - command in flight or response pending
//            jtag_tck/tms/tdi    - TAP drive, jtag_tdo - TAP return
// Revision : 1.0 - initial release
// ============================================================================
module jtag_host_drv #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [6:0]  cmd_len,
  input  logic [63:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        busy,
  output logic        jtag_tck,
  output logic        jtag_tms,
  output logic        jtag_tdi,
  input  logic        jtag_tdo
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_POST  = 3'd3,
    ST_RSP   = 3'd4
  } state_t;

  localparam logic [1:0] OP_TLR = 2'b00;
  localparam logic [1:0] OP_IR  = 2'b01;
  localparam logic [1:0] OP_DR  = 2'b10;
  localparam logic [1:0] OP_RTI = 2'b11;

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [6:0]  len_q, len_d;
  logic [63:0] data_q, data_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [7:0]  div_q, div_d;
  logic        tck_q, tck_d;
  logic        tms_q, tms_d;
  logic        tdi_q, tdi_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [63:0] rsp_data_q, rsp_data_d;

  logic [6:0]  cmd_len_eff;
  state_t      nxt_state;
  logic [6:0]  nxt_cnt;

  // Number of TCKs spent in the header phase. For the idle op the whole
  // command is "header" and its length is the requested TCK count.
  function automatic logic [6:0] hdr_tcks(input logic [1:0] op, input logic [6:0] len);
    logic [6:0] n;
    case (op)
      OP_TLR:  n = 7'd6;
      OP_IR:   n = 7'd4;
      OP_DR:   n = 7'd3;
      default: n = len;
    endcase
    return n;
  endfunction

  // TMS value for a given TCK position (phase + index within the phase).
  function automatic logic tms_for(input state_t st, input logic [6:0] cnt,
                                   input logic [1:0] op, input logic [6:0] len);
    logic tms;
    tms = 1'b0;
    case (st)
      ST_HDR: begin
        case (op)
          OP_TLR:  tms = (cnt < 7'd5);   // 1,1,1,1,1,0
          OP_IR:   tms = (cnt < 7'd2);   // 1,1,0,0
          OP_DR:   tms = (cnt == 7'd0);  // 1,0,0
          default: tms = 1'b0;           // Run-Test/Idle padding
        endcase
      end
      ST_SHIFT: tms = (cnt == len - 7'd1);  // leave Shift on the last bit
      ST_POST:  tms = (cnt == 7'd0);        // Exit1 -> Update -> Run-Test/Idle
      default:  tms = 1'b0;
    endcase
    return tms;
  endfunction

  // Length 0 behaves as 1, anything past 64 saturates at 64.
  always_comb begin
    cmd_len_eff = cmd_len;
    if (cmd_len == 7'd0) begin
      cmd_len_eff = 7'd1;
    end else if (cmd_len > 7'd64) begin
      cmd_len_eff = 7'd64;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    len_d       = len_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    nxt_state   = state_q;
    nxt_cnt     = cnt_q + 7'd1;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          // The accept edge also presents TMS for TCK 0 with TCK low.
          state_d    = ST_HDR;
          op_d       = cmd_op;
          len_d      = cmd_len_eff;
          data_d     = cmd_data;
          cnt_d      = 7'd0;
          div_d      = DIV_RELOAD;
          tck_d      = 1'b0;
          tms_d      = tms_for(ST_HDR, 7'd0, cmd_op, cmd_len_eff);
          tdi_d      = 1'b0;
          rsp_data_d = '0;
        end
      end

      ST_HDR, ST_SHIFT, ST_POST: begin
        if (div_q == 8'd0) begin
          div_d = DIV_RELOAD;
          if (!tck_q) begin
            // Rising TCK: the target launched TDO on the previous fall.
            tck_d = 1'b1;
            if (state_q == ST_SHIFT) begin
              rsp_data_d[cnt_q[5:0]] = jtag_tdo;
            end
          end else begin
            // Falling TCK ends the current bit; work out the next position.
            tck_d = 1'b0;
            case (state_q)
              ST_HDR: begin
                if (cnt_q == hdr_tcks(op_q, len_q) - 7'd1) begin
                  nxt_cnt = 7'd0;
                  if (op_q == OP_IR || op_q == OP_DR) begin
                    nxt_state = ST_SHIFT;
                  end else begin
                    nxt_state = ST_RSP;
                  end
                end
              end
              ST_SHIFT: begin
                if (cnt_q == len_q - 7'd1) begin
                  nxt_state = ST_POST;
                  nxt_cnt   = 7'd0;
                end
              end
              default: begin
                if (cnt_q == 7'd1) begin
                  nxt_state = ST_RSP;
                end
              end
            endcase

            state_d = nxt_state;
            cnt_d   = nxt_cnt;
            if (nxt_state == ST_RSP) begin
              // TMS is already 0 here, so the TAP parks in Run-Test/Idle.
              rsp_valid_d = 1'b1;
              tdi_d       = 1'b0;
            end else begin
              tms_d = tms_for(nxt_state, nxt_cnt, op_q, len_q);
              tdi_d = (nxt_state == ST_SHIFT) ? data_q[nxt_cnt[5:0]] : 1'b0;
            end
          end
        end else begin
          div_d = div_q - 8'd1;
        end
      end

      ST_RSP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_TLR;
      len_q       <= 7'd0;
      data_q      <= '0;
      cnt_q       <= 7'd0;
      div_q       <= 8'd0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      len_q       <= len_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign jtag_tck  = tck_q;
  assign jtag_tms  = tms_q;
  assign jtag_tdi  = tdi_q;

endmodule
`default_nettype wire
